mips_prog_loader: RTL and testbench

// Stream-fed program loader and run controller for the mips_adv core. Accepts 32-bit

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mips_prog_loader_if.sv | 32 +++
 rtl/mips_loader_wr_port.sv | 54 +++++
 rtl/mips_prog_loader.sv | 140 ++++++++++++++
 tb/tb_mips_prog_loader.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Shared types and constants for the mips_adv core and its loader.
// Rev    : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam int         INSTR_W = 32;
  localparam logic [5:0] OPC_HLT = 6'h3f;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/mips_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module : mips_prog_loader_if
// Brief  : Instruction stream in, instruction-memory write port out.
// Rev    : 1.0  initial release
// ============================================================================
interface mips_prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  import mips_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [INSTR_W-1:0] s_data;
  logic               s_last;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;

  // master = program source / memory owner, slave = loader
  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mips_loader_wr_port.sv
`default_nettype none
// ============================================================================
// Module : mips_loader_wr_port
// Brief  : Registered instruction-memory write stage with its write pointer.
// Rev    : 1.0  initial release
// ============================================================================
module mips_loader_wr_port
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  wire logic               clk_in,
  input  wire logic               reset,
  input  wire logic               accept_i,
  input  wire logic               clear_i,
  input  wire logic [INSTR_W-1:0] data_i,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [INSTR_W-1:0]      mem_wdata_o,
  output logic [ADDR_W:0]         wr_ptr_o
);

  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] mem_wdata_q;
  logic [ADDR_W:0]    wr_ptr_q;

  // wr_ptr is one wider than the address so it can report a completely full memory
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ptr_q    <= '0;
    end else begin
      mem_we_q <= accept_i;
      if (accept_i) begin
        mem_addr_q  <= wr_ptr_q[ADDR_W-1:0];
        mem_wdata_q <= data_i;
      end
      if (clear_i)
        wr_ptr_q <= '0;
      else if (accept_i)
        wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wr_ptr_o    = wr_ptr_q;

endmodule
`default_nettype wire

// File: rtl/mips_prog_loader.sv
`default_nettype none
// ============================================================================
// Module : mips_prog_loader
// Brief  : Streams a program into instruction memory, then runs the core.
// Rev    : 1.0  initial release
// ============================================================================
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 4,
  parameter int TIMEOUT  = 100000,
  parameter int CYC_W    = 32
) (
  input  wire logic           clk_in,
  input  wire logic           reset,
  mips_prog_loader_if.slave   bus,
  input  wire logic           reload,
  output logic                cpu_rst,
  input  wire logic           cpu_halted,
  output logic                load_done,
  output logic                run_done,
  output logic [ADDR_W:0]     word_count,
  output logic [CYC_W-1:0]    run_cycles,
  output logic                err_overflow,
  output logic                err_timeout
);

  localparam int              c_hold_w    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
  localparam logic [CYC_W-1:0]    c_timeout   = CYC_W'(TIMEOUT);

  loader_state_e       state_q;
  logic [c_hold_w-1:0] hold_q;
  logic                cpu_rst_q;
  logic                load_done_q;
  logic                run_done_q;
  logic [ADDR_W:0]     word_count_q;
  logic [CYC_W-1:0]    run_cycles_q;
  logic [CYC_W-1:0]    run_cycles_d;
  logic                err_overflow_q;
  logic                err_timeout_q;

  logic                accept;
  logic                at_top;
  logic                timeout_hit;
  logic [ADDR_W:0]     wr_ptr;

  assign bus.s_ready  = (state_q == ST_LOAD) && !reload;
  assign accept       = bus.s_valid && bus.s_ready;
  assign at_top       = &wr_ptr[ADDR_W-1:0];
  assign run_cycles_d = (&run_cycles_q) ? run_cycles_q : run_cycles_q + 1'b1;
  assign timeout_hit  = (TIMEOUT != 0) && (run_cycles_d == c_timeout);

  mips_loader_wr_port #(
    .ADDR_W (ADDR_W)
  ) u_wr_port (
    .clk_in      (clk_in),
    .reset       (reset),
    .accept_i    (accept),
    .clear_i     (reload),
    .data_i      (bus.s_data),
    .mem_we_o    (bus.mem_we),
    .mem_addr_o  (bus.mem_addr),
    .mem_wdata_o (bus.mem_wdata),
    .wr_ptr_o    (wr_ptr)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_LOAD;
      hold_q         <= '0;
      cpu_rst_q      <= 1'b1;
      load_done_q    <= 1'b0;
      run_done_q     <= 1'b0;
      word_count_q   <= '0;
      run_cycles_q   <= '0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else if (reload) begin
      state_q        <= ST_LOAD;
      hold_q         <= '0;
      cpu_rst_q      <= 1'b1;
      load_done_q    <= 1'b0;
      run_done_q     <= 1'b0;
      run_cycles_q   <= '0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          // a beat landing in the last word closes the load even without s_last
          if (accept && (bus.s_last || at_top)) begin
            state_q <= ST_FLUSH;
            hold_q  <= '0;
            if (!bus.s_last)
              err_overflow_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (hold_q == c_hold_last) begin
            state_q      <= ST_RUN;
            cpu_rst_q    <= 1'b0;
            load_done_q  <= 1'b1;
            word_count_q <= wr_ptr;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_RUN: begin
          run_cycles_q <= run_cycles_d;
          if (cpu_halted) begin
            state_q    <= ST_DONE;
            run_done_q <= 1'b1;
          end else if (timeout_hit) begin
            state_q       <= ST_DONE;
            run_done_q    <= 1'b1;
            err_timeout_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign cpu_rst      = cpu_rst_q;
  assign load_done    = load_done_q;
  assign run_done     = run_done_q;
  assign word_count   = word_count_q;
  assign run_cycles   = run_cycles_q;
  assign err_overflow = err_overflow_q;
  assign err_timeout  = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_prog_loader
// Brief  : Directed self-checking bench for the program loader.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips_prog_loader;

  localparam int ADDR_W   = 3;
  localparam int RST_HOLD = 4;
  localparam int TIMEOUT  = 50;
  localparam int CYC_W    = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              reload = 1'b0;
  logic              cpu_halted = 1'b0;
  logic              cpu_rst;
  logic              load_done;
  logic              run_done;
  logic [ADDR_W:0]   word_count;
  logic [CYC_W-1:0]  run_cycles;
  logic              err_overflow;
  logic              err_timeout;

  mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_prog_loader #(
    .ADDR_W   (ADDR_W),
    .RST_HOLD (RST_HOLD),
    .TIMEOUT  (TIMEOUT),
    .CYC_W    (CYC_W)
  ) dut (
    .clk_in       (clk),
    .reset        (rst_n),
    .bus          (bus),
    .reload       (reload),
    .cpu_rst      (cpu_rst),
    .cpu_halted   (cpu_halted),
    .load_done    (load_done),
    .run_done     (run_done),
    .word_count   (word_count),
    .run_cycles   (run_cycles),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write log captured from the memory port
  int                cyc = 0;
  int                wr_n = 0;
  int                last_we_cyc = 0;
  int                rst_fall_cyc = 0;
  logic              prev_rst = 1'b1;
  logic [ADDR_W-1:0] wr_addr [16];
  logic [31:0]       wr_data [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we && wr_n < 16) begin
      wr_addr[wr_n] = bus.mem_addr;
      wr_data[wr_n] = bus.mem_wdata;
      wr_n++;
      last_we_cyc = cyc;
    end
    if (prev_rst && !cpu_rst) rst_fall_cyc = cyc;
    prev_rst = cpu_rst;
  end

  logic [31:0] prog_a [6];
  logic [31:0] prog_b [6];

  task automatic clear_log();
    #1 wr_n = 0;
  endtask

  task automatic send_prog(input logic [31:0] w [6], input bit gaps);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = w[i];
      bus.s_last  = (i == 5);
      if (gaps) begin
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 32'hdeadbeef;
      end
    end
    if (!gaps) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
    end
    bus.s_last = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int  n = 0;
    bit  seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      #1;
      n++;
      if (!cpu_rst) seen = 1'b1;
    end
    check({tag, "_run_reached"}, seen, 1'b1);
  endtask

  task automatic check_log(input string tag, input logic [31:0] w [6]);
    check({tag, "_nwrites"}, wr_n, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
      check($sformatf("%s_data%0d", tag, i), wr_data[i], w[i]);
    end
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    int n;
    int acc;
    prog_a = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h00222000, 32'h00832800, 32'hfc000000};
    prog_b = '{32'h280a0005, 32'h280b0000, 32'h016a5820, 32'h294affff, 32'h1540fffd, 32'hfc000000};
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // reset state
    #12;
    check("rst_s_ready", bus.s_ready, 1'b1);
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_run_done", run_done, 1'b0);
    check("rst_word_count", word_count, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_err_ovf", err_overflow, 1'b0);
    check("rst_err_tmo", err_timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();

    // back-to-back load, halt after 10 RUN cycles
    send_prog(prog_a, 1'b0);
    wait_run("a");
    check_log("a", prog_a);
    check("a_rst_hold", rst_fall_cyc - last_we_cyc, RST_HOLD);
    check("a_word_count", word_count, 6);
    check("a_load_done", load_done, 1'b1);
    check("a_s_ready_run", bus.s_ready, 1'b0);
    check("a_run_cycles0", run_cycles, 0);
    repeat (9) @(negedge clk);
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
    #1;
    check("a_run_done", run_done, 1'b1);
    check("a_run_cycles", run_cycles, 10);
    check("a_err_tmo", err_timeout, 1'b0);
    check("a_cpu_rst_done", cpu_rst, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("a_run_cycles_hold", run_cycles, 10);

    // reload with a beat in the same cycle: beat must be refused
    @(negedge clk);
    reload = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h11111111;
    bus.s_last  = 1'b1;
    #1;
    check("b_ready_in_reload", bus.s_ready, 1'b0);
    @(negedge clk);
    reload = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    #1;
    check("b_mem_we_after", bus.mem_we, 1'b0);
    check("b_s_ready", bus.s_ready, 1'b1);
    check("b_cpu_rst", cpu_rst, 1'b1);
    check("b_load_done", load_done, 1'b0);
    check("b_run_done", run_done, 1'b0);
    check("b_run_cycles", run_cycles, 0);
    clear_log();

    // gapped load, then timeout
    send_prog(prog_a, 1'b1);
    wait_run("b");
    check_log("b", prog_a);
    check("b_word_count", word_count, 6);
    n = 0;
    while (n < 100 && !run_done) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t_cycles_to_done", n, TIMEOUT);
    check("t_err_tmo", err_timeout, 1'b1);
    check("t_run_cycles", run_cycles, TIMEOUT);

    // second program, then reload during RUN
    pulse_reload();
    clear_log();
    send_prog(prog_b, 1'b0);
    wait_run("c");
    check_log("c", prog_b);
    check("c_err_tmo_cleared", err_timeout, 1'b0);
    repeat (3) @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    #1;
    check("c_cpu_rst", cpu_rst, 1'b1);
    check("c_run_cycles", run_cycles, 0);
    check("c_s_ready", bus.s_ready, 1'b1);
    check("c_load_done", load_done, 1'b0);
    clear_log();

    // overflow: 9 beats, no s_last
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'ha0 + i;
      bus.s_last  = 1'b0;
      #1;
      if (bus.s_ready) acc++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    wait_run("o");
    check("o_accepted", acc, 8);
    check("o_nwrites", wr_n, 8);
    check("o_addr_first", wr_addr[0], 0);
    check("o_addr_last", wr_addr[7], 7);
    check("o_data_last", wr_data[7], 32'ha7);
    check("o_err_ovf", err_overflow, 1'b1);
    check("o_word_count", word_count, 8);

    // halt and timeout in the same cycle: halt wins
    repeat (TIMEOUT - 1) @(negedge clk);
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
    #1;
    check("h_run_done", run_done, 1'b1);
    check("h_err_tmo", err_timeout, 1'b0);
    check("h_run_cycles", run_cycles, TIMEOUT);
    check("h_err_ovf_sticky", err_overflow, 1'b1);

    // asynchronous reset mid-load
    pulse_reload();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = prog_a[i];
      bus.s_last  = 1'b0;
    end
    @(posedge clk);
    #2;
    bus.s_valid = 1'b0;
    check("r_mem_we_pre", bus.mem_we, 1'b1);
    check("r_mem_addr_pre", bus.mem_addr, 2);
    rst_n = 1'b0;
    #1;
    check("r_mem_we", bus.mem_we, 1'b0);
    check("r_mem_addr", bus.mem_addr, 0);
    check("r_mem_wdata", bus.mem_wdata, 0);
    check("r_word_count", word_count, 0);
    check("r_s_ready", bus.s_ready, 1'b1);
    check("r_cpu_rst", cpu_rst, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    send_prog(prog_a, 1'b0);
    wait_run("r");
    check_log("r", prog_a);
    check("r_word_count_final", word_count, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
